// File: rtl/psum_xchg_ctrl_if.sv
// Port bundle for the per-core partial-sum exchange sequencer: pass control,
// local sum input, outbound/inbound FIFO handshakes and the normalization stage.
interface psum_xchg_ctrl_if #(
   parameter int SUM_BW = 16,
   parameter int ROW_BW = 4
);
   logic              start;
   logic [ROW_BW:0]   num_rows;
   logic              sum_valid;
   logic [SUM_BW-1:0] sum_local;
   logic              fifo_full;
   logic              fifo_wr;
   logic [SUM_BW-1:0] fifo_wdata;
   logic              fifo_empty;
   logic              fifo_rd;
   logic [SUM_BW-1:0] fifo_rdata;
   logic              norm_start;
   logic [SUM_BW:0]   total_sum;
   logic              norm_done;
   logic              busy;
   logic              done;
   logic [ROW_BW-1:0] row_idx;
   logic [7:0]        stall_cnt;

   modport slave (
      input  start, num_rows, sum_valid, sum_local, fifo_full, fifo_empty,
             fifo_rdata, norm_done,
      output fifo_wr, fifo_wdata, fifo_rd, norm_start, total_sum, busy, done,
             row_idx, stall_cnt
   );

   modport master (
      output start, num_rows, sum_valid, sum_local, fifo_full, fifo_empty,
             fifo_rdata, norm_done,
      input  fifo_wr, fifo_wdata, fifo_rd, norm_start, total_sum, busy, done,
             row_idx, stall_cnt
   );
endinterface

// File: rtl/psum_xchg_ctrl.sv
// Per-core sequencer: pushes the local row sum to the peer, pops the peer's sum,
// issues the combined total to normalization and waits for it, row by row.
//
// state       | meaning
// ------------+--------------------------------------------------------
// S_IDLE      | waiting for start; num_rows latched on accept
// S_WAIT_SUM  | waiting for the local partial sum of row_idx
// S_PUSH      | writing local sum to outbound FIFO (stalls while full)
// S_WAIT_PEER | reading peer sum from inbound FIFO (stalls while empty)
// S_CAPTURE   | inbound data valid; register local + peer total
// S_NORM      | norm_start pulse
// S_WAIT_NORM | waiting for norm_done; advance row or finish
// S_DONE      | done pulse, back to idle
module psum_xchg_ctrl #(
   parameter int SUM_BW = 16,
   parameter int ROW_BW = 4
) (
   input  logic              clk_i,
   input  logic              reset_ni,
   psum_xchg_ctrl_if.slave   xchg
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_SUM,
      S_PUSH,
      S_WAIT_PEER,
      S_CAPTURE,
      S_NORM,
      S_WAIT_NORM,
      S_DONE
   } state_t;

   state_t            state_q;
   logic [ROW_BW:0]   num_rows_q;
   logic [ROW_BW-1:0] row_idx_q;
   logic [7:0]        stall_cnt_q;
   logic [SUM_BW-1:0] wdata_q;
   logic [SUM_BW:0]   total_q;
   logic              norm_start_q;
   logic              done_q;

   logic [7:0]        stall_cnt_d;
   logic              row_last_d;

   assign stall_cnt_d = (stall_cnt_q == 8'hFF) ? stall_cnt_q : stall_cnt_q + 8'd1;
   assign row_last_d  = ({1'b0, row_idx_q} == (num_rows_q - (ROW_BW+1)'(1)));

   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         state_q      <= S_IDLE;
         num_rows_q   <= '0;
         row_idx_q    <= '0;
         stall_cnt_q  <= '0;
         wdata_q      <= '0;
         total_q      <= '0;
         norm_start_q <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         norm_start_q <= 1'b0;
         done_q       <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (xchg.start) begin
                  num_rows_q  <= xchg.num_rows;
                  row_idx_q   <= '0;
                  stall_cnt_q <= '0;
                  if (xchg.num_rows == '0) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= S_WAIT_SUM;
                  end
               end
            end
            S_WAIT_SUM: begin
               if (xchg.sum_valid) begin
                  wdata_q <= xchg.sum_local;
                  state_q <= S_PUSH;
               end
            end
            S_PUSH: begin
               if (xchg.fifo_full) begin
                  stall_cnt_q <= stall_cnt_d;
               end else begin
                  state_q <= S_WAIT_PEER;
               end
            end
            S_WAIT_PEER: begin
               if (xchg.fifo_empty) begin
                  stall_cnt_q <= stall_cnt_d;
               end else begin
                  state_q <= S_CAPTURE;
               end
            end
            S_CAPTURE: begin
               // Extra MSB keeps the sum of two full-scale words exact.
               total_q      <= {1'b0, wdata_q} + {1'b0, xchg.fifo_rdata};
               norm_start_q <= 1'b1;
               state_q      <= S_NORM;
            end
            S_NORM: begin
               state_q <= S_WAIT_NORM;
            end
            S_WAIT_NORM: begin
               if (xchg.norm_done) begin
                  if (row_last_d) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     row_idx_q <= row_idx_q + ROW_BW'(1);
                     state_q   <= S_WAIT_SUM;
                  end
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   // FIFO strobes decode straight from state so a stalled cycle never strobes.
   assign xchg.fifo_wr    = (state_q == S_PUSH) && !xchg.fifo_full;
   assign xchg.fifo_rd    = (state_q == S_WAIT_PEER) && !xchg.fifo_empty;
   assign xchg.busy       = (state_q != S_IDLE);
   assign xchg.fifo_wdata = wdata_q;
   assign xchg.total_sum  = total_q;
   assign xchg.norm_start = norm_start_q;
   assign xchg.done       = done_q;
   assign xchg.row_idx    = row_idx_q;
   assign xchg.stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_psum_xchg_ctrl.sv
// Randomized bench for psum_xchg_ctrl: per-row cycle-offset timing model with
// random stall/latency parameters and random noise on every don't-care input.
module tb_psum_xchg_ctrl;
   localparam int SUM_BW = 16;
   localparam int ROW_BW = 4;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   psum_xchg_ctrl_if #(.SUM_BW(SUM_BW), .ROW_BW(ROW_BW)) xif ();

   psum_xchg_ctrl #(.SUM_BW(SUM_BW), .ROW_BW(ROW_BW)) dut (
      .clk_i    (clk),
      .reset_ni (reset_n),
      .xchg     (xif)
   );

   int n_tests = 0;
   int n_fail  = 0;

   logic [SUM_BW-1:0] row_loc  [16];
   logic [SUM_BW-1:0] row_peer [16];
   int                row_nf   [16];
   int                row_ne   [16];
   int                row_nd   [16];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic rand_inputs();
      xif.start      = 1'($urandom);
      xif.num_rows   = 5'($urandom);
      xif.sum_valid  = 1'($urandom);
      xif.sum_local  = 16'($urandom);
      xif.fifo_full  = 1'($urandom);
      xif.fifo_empty = 1'($urandom);
      xif.fifo_rdata = 16'($urandom);
      xif.norm_done  = 1'($urandom);
   endtask

   task automatic fill_rows();
      for (int i = 0; i < 16; i++) begin
         row_loc[i]  = 16'($urandom);
         row_peer[i] = 16'($urandom);
         row_nf[i]   = $urandom_range(0, 3);
         row_ne[i]   = $urandom_range(0, 3);
         row_nd[i]   = $urandom_range(0, 3);
      end
   endtask

   task automatic chk_all_zero();
      chk("rst_fifo_wr",    32'(xif.fifo_wr),    0);
      chk("rst_fifo_rd",    32'(xif.fifo_rd),    0);
      chk("rst_fifo_wdata", 32'(xif.fifo_wdata), 0);
      chk("rst_total_sum",  32'(xif.total_sum),  0);
      chk("rst_norm_start", 32'(xif.norm_start), 0);
      chk("rst_done",       32'(xif.done),       0);
      chk("rst_busy",       32'(xif.busy),       0);
      chk("rst_row_idx",    32'(xif.row_idx),    0);
      chk("rst_stall_cnt",  32'(xif.stall_cnt),  0);
   endtask

   // Row timeline from the accepted sum_valid at c=0: nf full cycles, then
   // ne empty cycles, capture, norm_start, then nd cycles before norm_done.
   task automatic drive_row(input int r, input bit abort, output bit aborted);
      int nf = row_nf[r];
      int ne = row_ne[r];
      int nd = row_nd[r];
      int p  = nf + 2;
      int w  = nf + ne + 5;
      int len = nf + ne + 6 + nd;
      logic [SUM_BW:0] exp_total;
      exp_total = {1'b0, row_loc[r]} + {1'b0, row_peer[r]};
      aborted = 1'b0;
      for (int c = 0; c < len; c++) begin
         @(posedge clk); #1;
         rand_inputs();
         if (c == 0) begin
            xif.sum_valid = 1'b1;
            xif.sum_local = row_loc[r];
         end
         if (c >= 1 && c <= nf) xif.fifo_full = 1'b1;
         if (c == nf + 1) xif.fifo_full = 1'b0;
         if (c >= p && c < p + ne) xif.fifo_empty = 1'b1;
         if (c == p + ne) xif.fifo_empty = 1'b0;
         if (c == p + ne + 1) xif.fifo_rdata = row_peer[r];
         if (c >= w && c < w + nd) xif.norm_done = 1'b0;
         if (c == w + nd) xif.norm_done = 1'b1;
         if (abort && c == p) reset_n = 1'b0;
         @(negedge clk);
         chk("fifo_wr", 32'(xif.fifo_wr), 32'(c == nf + 1));
         if (c == nf + 1) chk("fifo_wdata", 32'(xif.fifo_wdata), 32'(row_loc[r]));
         chk("fifo_rd", 32'(xif.fifo_rd), 32'(c == p + ne));
         chk("norm_start", 32'(xif.norm_start), 32'(c == nf + ne + 4));
         if (c == nf + ne + 4) chk("total_sum", 32'(xif.total_sum), 32'(exp_total));
         chk("busy", 32'(xif.busy), 1);
         chk("done", 32'(xif.done), 0);
         chk("row_idx", 32'(xif.row_idx), 32'(r));
         if (abort && c == p) begin
            @(posedge clk); #1;
            rand_inputs();
            xif.start      = 1'b0;
            xif.fifo_empty = 1'b0;
            reset_n        = 1'b1;
            @(negedge clk);
            chk_all_zero();
            aborted = 1'b1;
            return;
         end
      end
   endtask

   task automatic run_pass(input int n, input int abort_row);
      int  stall_exp = 0;
      bit  ab;
      @(posedge clk); #1;
      rand_inputs();
      xif.start    = 1'b1;
      xif.num_rows = 5'(n);
      @(negedge clk);
      chk("idle_busy", 32'(xif.busy), 0);
      chk("idle_wr",   32'(xif.fifo_wr), 0);
      chk("idle_rd",   32'(xif.fifo_rd), 0);
      for (int r = 0; r < n; r++) begin
         int gap = $urandom_range(0, 2);
         repeat (gap) begin
            @(posedge clk); #1;
            rand_inputs();
            xif.sum_valid = 1'b0;
            @(negedge clk);
            chk("gap_busy",  32'(xif.busy), 1);
            chk("gap_wr",    32'(xif.fifo_wr), 0);
            chk("gap_rd",    32'(xif.fifo_rd), 0);
            chk("gap_row",   32'(xif.row_idx), 32'(r));
            chk("gap_nstart", 32'(xif.norm_start), 0);
         end
         drive_row(r, r == abort_row, ab);
         if (ab) return;
         stall_exp += row_nf[r] + row_ne[r];
      end
      if (stall_exp > 255) stall_exp = 255;
      @(posedge clk); #1;
      rand_inputs();
      @(negedge clk);
      chk("pass_done",  32'(xif.done), 1);
      chk("pass_busy",  32'(xif.busy), 1);
      chk("pass_wr",    32'(xif.fifo_wr), 0);
      chk("pass_rd",    32'(xif.fifo_rd), 0);
      @(posedge clk); #1;
      rand_inputs();
      xif.start = 1'b0;
      @(negedge clk);
      chk("end_done",  32'(xif.done), 0);
      chk("end_busy",  32'(xif.busy), 0);
      chk("end_stall", 32'(xif.stall_cnt), 32'(stall_exp));
   endtask

   initial begin
      rand_inputs();
      xif.start = 1'b0;
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_all_zero();
      @(posedge clk); #1;
      xif.start = 1'b0;
      reset_n = 1'b1;

      // single row, zero stalls: 0x1234 + 0x0F00
      fill_rows();
      row_loc[0] = 16'h1234; row_peer[0] = 16'h0F00;
      row_nf[0] = 0; row_ne[0] = 0; row_nd[0] = 0;
      run_pass(1, -1);

      // full-scale operands
      fill_rows();
      row_loc[0] = 16'hFFFF; row_peer[0] = 16'hFFFF;
      run_pass(1, -1);

      // 3 full + 5 empty stall cycles
      fill_rows();
      row_nf[0] = 3; row_ne[0] = 5; row_nd[0] = 0;
      run_pass(1, -1);

      // 16 rows, norm_done 2 cycles late on each
      fill_rows();
      for (int i = 0; i < 16; i++) row_nd[i] = 2;
      run_pass(16, -1);

      // empty pass
      run_pass(0, -1);

      // stall counter saturation
      fill_rows();
      row_ne[0] = 300;
      run_pass(1, -1);

      // reset while waiting for peer on row 3, then a clean pass
      fill_rows();
      row_ne[3] = 2;
      run_pass(8, 3);
      fill_rows();
      run_pass(4, -1);

      repeat (10) begin
         fill_rows();
         run_pass($urandom_range(1, 16), -1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/psum_xchg_ctrl.md
# psum_xchg_ctrl

Per-core sequencer for the dual-core normalization-sum exchange. For each output row it takes the core's local partial sum, pushes it into the outbound cross-core FIFO, and pops the peer core's sum from the inbound FIFO. It then issues the combined total to the core's normalization stage and waits for completion. One instance sits beside each core and runs entirely in that core's clock domain; the FIFOs handle the domain crossing.

## Interface
- sum_bw, default 16, width of one partial sum (bw_psum+4)
- row_bw, default 4, width of row counter (max 2^row_bw rows per pass)
- clk  in  1  core clock, all logic on rising edge
- reset  in  1  synchronous, active-low; asserted while 0
- start  in  1  pulse; begins a pass, accepted only in IDLE
- num_rows  in  row_bw+1  rows this pass, sampled on accepted start; 0 = empty pass
- sum_valid  in  1  local sum available this cycle
- sum_local  in  sum_bw  local partial sum, valid with sum_valid
- fifo_full  in  1  outbound FIFO full
- fifo_wr  out  1  outbound write strobe
- fifo_wdata  out  sum_bw  outbound data
- fifo_empty  in  1  inbound FIFO empty
- fifo_rd  out  1  inbound read strobe
- fifo_rdata  in  sum_bw  inbound data, valid the cycle after fifo_rd
- norm_start  out  1  one-cycle pulse, total_sum valid
- total_sum  out  sum_bw+1  local + peer sum
- norm_done  in  1  normalization stage finished current row
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at end of pass
- row_idx  out  row_bw  index of row in progress
- stall_cnt  out  8  saturating count of FIFO-stall cycles in this pass

## Operation
- States: IDLE, WAIT_SUM, PUSH, WAIT_PEER, CAPTURE, NORM, WAIT_NORM, DONE.
- IDLE: on start, latch num_rows, clear row_idx and stall_cnt, go to WAIT_SUM. If num_rows==0, go straight to DONE instead.
- WAIT_SUM: on sum_valid, register sum_local into fifo_wdata and go to PUSH. sum_valid in any other state is ignored.
- PUSH: fifo_wr = !fifo_full (combinational decode).
  - If not full: go to WAIT_PEER.
  - If full: stay in PUSH and increment stall_cnt.
- WAIT_PEER: fifo_rd = !fifo_empty (combinational decode).
  - If not empty: go to CAPTURE.
  - If empty: stay and increment stall_cnt.
- CAPTURE: register total_sum = {1'b0,fifo_wdata} + {1'b0,fifo_rdata}. This is an unsigned, full-width add; it never overflows. Then go to NORM.
- NORM: norm_start=1 for one cycle, then go to WAIT_NORM.
- WAIT_NORM: wait for norm_done. norm_done is sampled only in this state.
  - If row_idx == num_rows-1: go to DONE.
  - Otherwise: row_idx+1, go to WAIT_SUM.
- DONE: done=1 for one cycle, then go to IDLE.
- Only the FSM writes or reads the FIFOs, so a full FIFO is never written and an empty FIFO is never read.
- stall_cnt saturates at 255. It holds its value after the pass until the next accepted start.
- start while busy is ignored, and num_rows is not re-sampled.
- fifo_wdata and total_sum hold their values until overwritten by the next row.

## Timing
- Reset (reset=0 at an edge):
  - state goes to IDLE.
  - Every registered output is 0: fifo_wdata, total_sum, norm_start, done, row_idx, stall_cnt.
  - busy=0.
  - fifo_wr=0 and fifo_rd=0, since they decode from IDLE.
- Reset mid-operation aborts the pass immediately, with no further FIFO strobes. Any word already pushed stays in the FIFO; draining it is the system's responsibility.
- Zero-stall row: sum_valid at cycle t, fifo_wr at t+1, fifo_rd at t+2, capture at t+3, norm_start at t+4.
  - If norm_done is high at t+5, the next WAIT_SUM state is at t+6, so a row takes 6 cycles minimum.
- Each stall cycle in PUSH or WAIT_PEER adds exactly 1 cycle and 1 count to stall_cnt.
- done is asserted one cycle after the final norm_done. busy falls on the cycle after done.
- An empty pass: start at t, DONE at t+1, IDLE at t+2.

## Test plan
- Single row: num_rows=1, sum_local=0x1234 at t, FIFOs never full/empty, fifo_rdata=0x0F00. Required: fifo_wr at t+1 with wdata 0x1234; fifo_rd at t+2; norm_start at t+4 with total_sum=0x02134; norm_done at t+5 → done at t+6; stall_cnt=0.
- Overflow width: sum_local=0xFFFF, peer=0xFFFF → total_sum=0x1FFFE.
- Stalls: fifo_full high for 3 cycles during PUSH and fifo_empty high for 5 cycles during WAIT_PEER. Required: exactly one fifo_wr and one fifo_rd, norm_start delayed 8 cycles, stall_cnt=8.
- Multi-row: num_rows=16, with norm_done delayed 2 cycles each row. Required: row_idx runs 0..15, 16 norm_start pulses, one done. A start pulsed mid-pass is ignored, and an extra sum_valid in WAIT_NORM is ignored.
- Empty pass and saturation:
  - num_rows=0: done at start+1 with no FIFO strobes.
  - fifo_empty held for 300 cycles: stall_cnt saturates at 255.
- Reset mid-pass: reset=0 while in WAIT_PEER with row_idx=3. Required: all outputs 0 next cycle, no fifo_rd. A new start then runs cleanly from row 0.
